// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a contiguous BRAM address range out on valid/ready; optional abort input via BRAM_STREAM_READER_ABORT_EN
module bram_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
`ifdef BRAM_STREAM_READER_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_wr,
   input  logic [DATA_WIDTH-1:0] bram_data_out,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH:0] len_q, issued, beats;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [RD_LATENCY:0] pipe;
   logic [CW-1:0] occ, inflight, credit;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
   logic issue, wr_en, pop, abort_now;
`ifdef BRAM_STREAM_READER_ABORT_EN
   assign abort_now = abort && (state == READ || state == DRAIN);
`else
   assign abort_now = 1'b0;
`endif
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign busy    = state != IDLE;
   assign done    = state == DONE;
   assign bram_wr = 1'b0;
   assign wr_en   = pipe[RD_LATENCY];
   assign m_valid = occ != '0 && !abort_now;
   assign m_data  = m_valid ? fifo[rd_ptr] : '0;
   assign m_last  = m_valid && (beats + 1'b1 == len_q);
   assign pop     = m_valid && m_ready;
   // a word popped this cycle frees its slot, so it counts as credit already
   assign credit  = occ + inflight - CW'(pop);
   // next-state and issue decision
   always_comb begin
      state_nxt = state;
      issue = 1'b0;
      case (state)
         IDLE: state_nxt = start ? (length == '0 ? DONE : READ) : IDLE;
         READ: begin
            issue = !abort_now && credit < CW'(FIFO_DEPTH);
            state_nxt = abort_now ? DONE : (issue && issued == len_q - 1'b1) ? DRAIN : READ;
         end
         DRAIN: state_nxt = (abort_now || (pop && m_last)) ? DONE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end
   // state, command latch, address generation and beat counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         len_q <= '0;
         issued <= '0;
         beats <= '0;
         next_addr <= '0;
         bram_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            len_q <= length;
            next_addr <= start_addr;
            issued <= '0;
            beats <= '0;
         end
         if (issue) begin
            bram_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            issued <= issued + 1'b1;
         end
         if (pop) beats <= beats + 1'b1;
      end
   end
   // in-flight flags and FIFO bookkeeping; the extra pipe stage covers the registered address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
         inflight <= '0;
         occ <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (abort_now) begin
         pipe <= '0;
         inflight <= '0;
         occ <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         pipe <= {pipe[RD_LATENCY-1:0], issue};
         inflight <= inflight + CW'(issue) - CW'(wr_en);
         occ <= occ + CW'(wr_en) - CW'(pop);
         if (wr_en) wr_ptr <= bump(wr_ptr);
         if (pop) rd_ptr <= bump(rd_ptr);
      end
   end
   // FIFO storage captures returning BRAM data
   always_ff @(posedge clk) begin
      if (wr_en && !abort_now) fifo[wr_ptr] <= bram_data_out;
   end
endmodule
